// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding and ALU operand selection.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [31:0]   id_pc,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm16,
    input  logic [4:0]    id_shamt,
    input  logic [FW-1:0] id_alu_func,
    input  logic [1:0]    id_bsel,
    input  logic [1:0]    id_shmode,
    input  logic          id_wr_en,
    input  logic          exm_wr_en,
    input  logic [RW-1:0] exm_wr_addr,
    input  logic [DW-1:0] exm_wr_data,
    input  logic          mwb_wr_en,
    input  logic [RW-1:0] mwb_wr_addr,
    input  logic [DW-1:0] mwb_wr_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [FW-1:0] alu_func,
    output logic          ex_valid,
    output logic          ex_wr_en,
    output logic [RW-1:0] ex_rd_addr,
    output logic [DW-1:0] ex_store_data,
    output logic [31:0]   ex_pc
);
    localparam logic [FW-1:0] ALU_ADD = '0;

    typedef struct packed {
        logic          valid;
        logic          wr_en;
        logic [RW-1:0] rs_addr;
        logic [RW-1:0] rt_addr;
        logic [RW-1:0] rd_addr;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [15:0]   imm;
        logic [4:0]    shamt;
        logic [FW-1:0] func;
        logic [1:0]    bsel;
        logic [1:0]    shmode;
        logic [31:0]   pc;
    } ex_t;

    localparam ex_t EX_BUBBLE = '{func: ALU_ADD, default: '0};

    ex_t           ex_q, ex_d;
    logic [DW-1:0] rs_f, rt_f;
    logic          shift_c, shift_v;

    always_comb begin
        rs_f = (ex_q.rs_addr == '0) ? ex_q.rs_data :
               (exm_wr_en && exm_wr_addr == ex_q.rs_addr) ? exm_wr_data :
               (mwb_wr_en && mwb_wr_addr == ex_q.rs_addr) ? mwb_wr_data : ex_q.rs_data;
        rt_f = (ex_q.rt_addr == '0) ? ex_q.rt_data :
               (exm_wr_en && exm_wr_addr == ex_q.rt_addr) ? exm_wr_data :
               (mwb_wr_en && mwb_wr_addr == ex_q.rt_addr) ? mwb_wr_data : ex_q.rt_data;
        shift_c = ex_q.shmode == 2'b01;
        shift_v = ex_q.shmode == 2'b10;
        alu_a = (shift_c || shift_v) ? rt_f : rs_f;
        alu_b = shift_c ? DW'(ex_q.shamt) :
                shift_v ? DW'(rs_f[4:0]) :
                (ex_q.bsel == 2'b00) ? rt_f :
                (ex_q.bsel == 2'b01) ? {{(DW-16){ex_q.imm[15]}}, ex_q.imm} :
                (ex_q.bsel == 2'b10) ? DW'(ex_q.imm) : {ex_q.imm, {(DW-16){1'b0}}};
        alu_func      = ex_q.func;
        ex_valid      = ex_q.valid;
        ex_wr_en      = ex_q.valid & ex_q.wr_en;
        ex_rd_addr    = ex_q.rd_addr;
        ex_store_data = rt_f;
        ex_pc         = ex_q.pc;
    end

    // A stalled instruction keeps refreshing its sources so a producer retiring mid-stall is not lost.
    always_comb begin
        ex_d         = ex_q;
        ex_d.rs_data = rs_f;
        ex_d.rt_data = rt_f;
        if (flush)
            ex_d = EX_BUBBLE;
        else if (!stall)
            ex_d = '{valid: id_valid, wr_en: id_valid & id_wr_en, rs_addr: id_rs_addr,
                     rt_addr: id_rt_addr, rd_addr: id_rd_addr, rs_data: id_rs_data,
                     rt_data: id_rt_data, imm: id_imm16, shamt: id_shamt, func: id_alu_func,
                     bsel: id_bsel, shmode: id_shmode, pc: id_pc};
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= EX_BUBBLE;
        else
            ex_q <= ex_d;
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: vector table plus stall/flush/reset sequences, expectations queued as stimulus is driven.
module tb_id_ex_operand_stage;
    logic        clk = 0;
    logic        rst, stall, flush, id_valid, id_wr_en;
    logic [31:0] id_pc, id_rs_data, id_rt_data;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
    logic [15:0] id_imm16;
    logic [3:0]  id_alu_func;
    logic [1:0]  id_bsel, id_shmode;
    logic        exm_wr_en, mwb_wr_en;
    logic [4:0]  exm_wr_addr, mwb_wr_addr;
    logic [31:0] exm_wr_data, mwb_wr_data;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_func;
    logic        ex_valid, ex_wr_en;
    logic [4:0]  ex_rd_addr;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16), .id_shamt(id_shamt),
        .id_alu_func(id_alu_func), .id_bsel(id_bsel), .id_shmode(id_shmode), .id_wr_en(id_wr_en),
        .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data),
        .mwb_wr_en(mwb_wr_en), .mwb_wr_addr(mwb_wr_addr), .mwb_wr_data(mwb_wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
        .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    typedef struct {
        logic v, we;
        logic [4:0] rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic [4:0] sh;
        logic [3:0] fn;
        logic [1:0] bsel, shm;
        logic xe;
        logic [4:0] xa;
        logic [31:0] xd;
        logic me;
        logic [4:0] ma;
        logic [31:0] md;
        logic [31:0] ea, eb, esd, pc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(logic v, logic we, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rsd, logic [31:0] rtd, logic [15:0] imm, logic [4:0] sh,
                                logic [3:0] fn, logic [1:0] bsel, logic [1:0] shm,
                                logic xe, logic [4:0] xa, logic [31:0] xd,
                                logic me, logic [4:0] ma, logic [31:0] md,
                                logic [31:0] ea, logic [31:0] eb, logic [31:0] esd);
        vec_t t;
        t.v = v; t.we = we; t.rs = rs; t.rt = rt; t.rd = rd; t.rsd = rsd; t.rtd = rtd;
        t.imm = imm; t.sh = sh; t.fn = fn; t.bsel = bsel; t.shm = shm;
        t.xe = xe; t.xa = xa; t.xd = xd; t.me = me; t.ma = ma; t.md = md;
        t.ea = ea; t.eb = eb; t.esd = esd; t.pc = 32'h0;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_wr_en = t.we; id_rs_addr = t.rs; id_rt_addr = t.rt; id_rd_addr = t.rd;
        id_rs_data = t.rsd; id_rt_data = t.rtd; id_imm16 = t.imm; id_shamt = t.sh;
        id_alu_func = t.fn; id_bsel = t.bsel; id_shmode = t.shm; id_pc = t.pc;
        exm_wr_en = t.xe; exm_wr_addr = t.xa; exm_wr_data = t.xd;
        mwb_wr_en = t.me; mwb_wr_addr = t.ma; mwb_wr_data = t.md;
    endtask

    task automatic rand_id();
        id_valid = 1'b1; id_wr_en = 1'b1; id_pc = $urandom;
        id_rs_addr = 5'($urandom_range(1, 31)); id_rt_addr = 5'($urandom_range(1, 31));
        id_rd_addr = 5'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm16 = 16'($urandom); id_shamt = 5'($urandom); id_alu_func = 4'($urandom_range(1, 15));
        id_bsel = 2'($urandom); id_shmode = 2'($urandom);
    endtask

    task automatic chk_bubble(input string n);
        chk({n, "_valid"}, 32'(ex_valid), 0);
        chk({n, "_wr"}, 32'(ex_wr_en), 0);
        chk({n, "_func"}, 32'(alu_func), 0);
        chk({n, "_a"}, alu_a, 0);
        chk({n, "_b"}, alu_b, 0);
        chk({n, "_sd"}, ex_store_data, 0);
        chk({n, "_pc"}, ex_pc, 0);
        chk({n, "_rd"}, 32'(ex_rd_addr), 0);
    endtask

    initial begin
        vec_t t, e;
        stall = 0; flush = 0; rst = 1;
        exm_wr_en = 0; exm_wr_addr = 0; exm_wr_data = 0;
        mwb_wr_en = 0; mwb_wr_addr = 0; mwb_wr_data = 0;
        rand_id();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_bubble("reset");
            rand_id();
        end
        rst = 0;

        vecs.push_back(mk(1,1,1,2,3,32'h10,0,16'hFFFC,0,4'h0,2'b01,2'b00, 0,0,0, 0,0,0, 32'h10,32'hFFFFFFFC,0));
        vecs.push_back(mk(1,1,1,2,3,32'h10,0,16'hFFFC,0,4'h0,2'b11,2'b00, 0,0,0, 0,0,0, 32'h10,32'hFFFC0000,0));
        vecs.push_back(mk(1,0,4,2,8,32'h22,32'h5,16'h8001,0,4'h3,2'b10,2'b00, 0,0,0, 0,0,0, 32'h22,32'h8001,32'h5));
        vecs.push_back(mk(1,1,4,3,9,32'h22,32'h1234,16'hFFFF,0,4'h1,2'b00,2'b00, 0,0,0, 0,0,0, 32'h22,32'h1234,32'h1234));
        vecs.push_back(mk(1,1,5,6,10,1,2,0,0,4'h0,2'b00,2'b00, 1,5,32'hAAAA, 1,5,32'hBBBB, 32'hAAAA,2,2));
        vecs.push_back(mk(1,1,5,6,10,1,2,0,0,4'h0,2'b00,2'b00, 0,5,32'hAAAA, 1,5,32'hBBBB, 32'hBBBB,2,2));
        vecs.push_back(mk(1,1,0,6,10,0,2,0,0,4'h0,2'b00,2'b00, 1,0,32'hCCCC, 1,0,32'hDDDD, 0,2,2));
        vecs.push_back(mk(1,1,5,6,10,1,2,0,0,4'h7,2'b00,2'b00, 1,6,32'h1111, 1,6,32'h2222, 1,32'h1111,32'h1111));
        vecs.push_back(mk(1,1,1,6,2,32'h99,1,16'hFFFF,4,4'h5,2'b01,2'b01, 0,0,0, 0,0,0, 1,4,1));
        vecs.push_back(mk(1,1,1,6,2,32'hFFFFFF23,32'h80,0,9,4'h6,2'b00,2'b10, 0,0,0, 0,0,0, 32'h80,3,32'h80));
        vecs.push_back(mk(1,1,1,6,2,32'h7,32'h8,16'h1234,9,4'h2,2'b10,2'b11, 0,0,0, 0,0,0, 32'h7,32'h1234,32'h8));
        vecs.push_back(mk(0,1,1,2,3,32'h10,32'h20,0,0,4'h0,2'b00,2'b00, 0,0,0, 0,0,0, 32'h10,32'h20,32'h20));
        vecs.push_back(mk(1,1,1,9,3,32'h5,32'h7,0,31,4'h0,2'b00,2'b01, 0,0,0, 1,9,32'h11, 32'h11,31,32'h11));
        vecs.push_back(mk(1,1,4,2,3,0,32'h40,0,0,4'h0,2'b00,2'b10, 1,4,32'h3F, 0,0,0, 32'h40,32'h1F,32'h40));

        foreach (vecs[i]) begin
            t = vecs[i];
            t.pc = 32'h1000 + 32'(i) * 4;
            drive(t);
            sb.push_back(t);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_a", i), alu_a, e.ea);
            chk($sformatf("v%0d_b", i), alu_b, e.eb);
            chk($sformatf("v%0d_sd", i), ex_store_data, e.esd);
            chk($sformatf("v%0d_func", i), 32'(alu_func), 32'(e.fn));
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(e.v));
            chk($sformatf("v%0d_wr", i), 32'(ex_wr_en), 32'(e.v & e.we));
            chk($sformatf("v%0d_rd", i), 32'(ex_rd_addr), 32'(e.rd));
            chk($sformatf("v%0d_pc", i), ex_pc, e.pc);
        end

        t = mk(1,1,1,7,12,32'h10,32'h3,0,0,4'h4,2'b00,2'b00, 0,0,0, 0,0,0, 32'h10,32'h3,32'h3);
        t.pc = 32'h2000;
        drive(t);
        @(posedge clk); #1;
        chk("stall_load_b", alu_b, 32'h3);
        stall = 1;
        rand_id();
        mwb_wr_en = 1; mwb_wr_addr = 7; mwb_wr_data = 32'h55;
        #1 chk("stall_c1_fwd_b", alu_b, 32'h55);
        @(posedge clk); #1;
        mwb_wr_en = 0;
        #1 chk("stall_c2_b", alu_b, 32'h55);
        chk("stall_c2_sd", ex_store_data, 32'h55);
        chk("stall_c2_pc", ex_pc, 32'h2000);
        @(posedge clk); #1;
        stall = 0;
        chk("stall_rel_b", alu_b, 32'h55);
        chk("stall_rel_sd", ex_store_data, 32'h55);
        chk("stall_rel_valid", 32'(ex_valid), 1);
        chk("stall_rel_rd", 32'(ex_rd_addr), 12);
        chk("stall_rel_func", 32'(alu_func), 4);

        rand_id();
        stall = 1; flush = 1;
        @(posedge clk); #1;
        chk_bubble("flush");
        stall = 0; flush = 0;

        rand_id();
        @(posedge clk); #1;
        chk("load_after_flush_valid", 32'(ex_valid), 1);
        stall = 1; rst = 1;
        @(posedge clk); #1;
        chk_bubble("rst_mid_stall");
        rst = 0; stall = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
